lsu_dmem_ctrl: RTL and testbench

LSU_DMEM_CTRL -- requirements
Module: lsu_dmem_ctrl

---
 rtl/lsu_pkg.sv | 75 +++++++
 rtl/lsu_load_align.sv | 39 +++
 rtl/lsu_dmem_ctrl.sv | 166 ++++++++++++++++
 tb/tb_lsu_dmem_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg -- shared definitions for the load/store data-memory controller.
//
// Contents:
//   lsu_op_e      request op codes (bit 3 = store, bit 2 = unsigned load,
//                 bits 1:0 = access size)
//   lsu_state_e   controller FSM states
//   SZ_*          access-size encodings taken from op[1:0]
//   ANSCODE_ADDR  word address watched by the optional answer-code monitor
//   op_legal / op_misaligned / lane_sel / lane_wdata helper functions
// ---------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [3:0] {
        OP_LB  = 4'h0,
        OP_LH  = 4'h1,
        OP_LW  = 4'h2,
        OP_LBU = 4'h4,
        OP_LHU = 4'h5,
        OP_SB  = 4'h8,
        OP_SH  = 4'h9,
        OP_SW  = 4'hA
    } lsu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_LOAD_WAIT,
        ST_RESP
    } lsu_state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [31:0] ANSCODE_ADDR = 32'h1001_0000;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_SB, OP_SH, OP_SW: return 1'b1;
            default:             return 1'b0;
        endcase
    endfunction

    // Size comes from op[1:0]; an illegal size is caught by op_legal.
    function automatic logic op_misaligned(input logic [3:0] op,
                                           input logic [1:0] off);
        case (op[1:0])
            SZ_HALF: return off[0];
            SZ_WORD: return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_sel(input logic [1:0] size,
                                            input logic [1:0] off);
        case (size)
            SZ_BYTE: return 4'b0001 << off;
            SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Store data is right-aligned; replicate it so every lane carries it.
    function automatic logic [31:0] lane_wdata(input logic [1:0]  size,
                                               input logic [31:0] wdata);
        case (size)
            SZ_BYTE: return {4{wdata[7:0]}};
            SZ_HALF: return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// ---------------------------------------------------------------------------
// lsu_load_align -- combinational load extraction and extension.
//
// Ports:
//   size        access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   is_unsigned 1 = zero-extend (LBU/LHU), 0 = sign-extend (LB/LH)
//   byte_off    byte address bits [1:0] of the load
//   rdata       raw 32-bit word from data memory
//   data        aligned, extended load result
// ---------------------------------------------------------------------------
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  byte_off,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        data     = '0;
        byte_val = rdata[{byte_off, 3'b000} +: 8];
        half_val = byte_off[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_BYTE: data = is_unsigned ? {24'h0, byte_val}
                                        : {{24{byte_val[7]}}, byte_val};
            SZ_HALF: data = is_unsigned ? {16'h0, half_val}
                                        : {{16{half_val[15]}}, half_val};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_dmem_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_dmem_ctrl -- single-outstanding load/store controller for a
// synchronous data memory (read data valid one clock after the address).
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake (ready only in IDLE)
//   req_op               LB/LH/LW/LBU/LHU/SB/SH/SW op code
//   req_addr, req_wdata  byte address, right-aligned store data
//   resp_valid           one-cycle completion pulse
//   resp_rdata, resp_err extended load data / misaligned-or-illegal flag,
//                        held until the next completion
//   dmem_we, dmem_addr   memory write enable and word address
//   dmem_wdata_sel       byte-lane select
//   dmem_wdata           lane-replicated store data
//   dmem_rdata           memory read data
//   ans_code             answer-code mirror
//
// Build option: define LSU_ANSCODE_MON_EN to mirror stores hitting
// ANSCODE_ADDR into ans_code; otherwise ans_code is tied to 0.
//
// Timing: accept edge -> ACCESS -> (LOAD_WAIT) -> RESP. Bad requests skip
// straight to RESP, so memory is never touched for them.
// ---------------------------------------------------------------------------
module lsu_dmem_ctrl
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_wdata_sel,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] ans_code
);

    lsu_state_e  state, state_nxt;
    logic [3:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        accept;
    logic        req_bad;
    logic        is_store;
    logic [31:0] load_data;

    assign accept   = req_valid && req_ready;
    assign req_bad  = !op_legal(req_op) || op_misaligned(req_op, req_addr[1:0]);
    assign is_store = op_q[3];

    // NOTE: state and datapath registers use non-blocking assignments so
    // every flop samples pre-edge values regardless of process order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Memory strobes are decoded from the state register only, so an
    // asynchronous reset removes dmem_we in the same instant.
    always_comb begin
        state_nxt      = state;
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        dmem_we        = 1'b0;
        dmem_addr      = '0;
        dmem_wdata_sel = '0;
        dmem_wdata     = '0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = req_bad ? ST_RESP : ST_ACCESS;
            end
            ST_ACCESS: begin
                dmem_addr      = {addr_q[31:2], 2'b00};
                dmem_wdata_sel = lane_sel(op_q[1:0], addr_q[1:0]);
                if (is_store) begin
                    dmem_we    = 1'b1;
                    dmem_wdata = lane_wdata(op_q[1:0], wdata_q);
                    state_nxt  = ST_RESP;
                end else begin
                    state_nxt  = ST_LOAD_WAIT;
                end
            end
            ST_LOAD_WAIT: state_nxt = ST_RESP;
            ST_RESP: begin
                resp_valid = 1'b1;
                state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    lsu_load_align u_load_align (
        .size        (op_q[1:0]),
        .is_unsigned (op_q[2]),
        .byte_off    (addr_q[1:0]),
        .rdata       (dmem_rdata),
        .data        (load_data)
    );

    // Response registers are written on the edge that enters RESP, then
    // held untouched until the next request reaches RESP.
    // NOTE: the request latches are reset too, so the outputs decoded from
    // them start at a known 0 and a reset mid-transaction leaves no residue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= req_op;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                if (req_bad) begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b1;
                end
            end
            case (state)
                ST_ACCESS: begin
                    if (is_store) begin
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                    end
                end
                ST_LOAD_WAIT: begin
                    resp_rdata <= load_data;
                    resp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef LSU_ANSCODE_MON_EN
    logic [31:0] ans_q;

    // Only stores reach dmem_we, and bad requests never reach ACCESS, so
    // the strobe itself qualifies a successful store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ans_q <= '0;
        end else if (dmem_we && dmem_addr == ANSCODE_ADDR) begin
            for (int i = 0; i < 4; i++) begin
                if (dmem_wdata_sel[i]) ans_q[8*i +: 8] <= dmem_wdata[8*i +: 8];
            end
        end
    end

    assign ans_code = ans_q;
`else
    assign ans_code = '0;
`endif

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_dmem_ctrl -- scoreboard bench for lsu_dmem_ctrl.
// The issuing process pushes expected responses (and expected memory write
// strobes for stores); monitors on the falling edge pop and compare.
// ---------------------------------------------------------------------------
module tb_lsu_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = 4'h0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wdata_sel;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic [31:0] ans_code;

    lsu_dmem_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata_sel (dmem_wdata_sel),
        .dmem_wdata     (dmem_wdata),
        .dmem_rdata     (dmem_rdata),
        .ans_code       (ans_code)
    );

    always #5 clk = ~clk;

    // Synchronous data memory: 256 words, one-cycle read latency.
    logic [31:0] mem [256];
    logic [31:0] mem_rd_q;
    assign dmem_rdata = mem_rd_q;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            mem_rd_q <= '0;
        end else begin
            mem_rd_q <= mem[dmem_addr[9:2]];
            if (dmem_we) begin
                for (int i = 0; i < 4; i++) begin
                    if (dmem_wdata_sel[i]) mem[dmem_addr[9:2]][8*i +: 8] <= dmem_wdata[8*i +: 8];
                end
            end
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc_cyc;
    } resp_exp_t;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
    } acc_exp_t;

    resp_exp_t sb[$];
    acc_exp_t  acc_q[$];
    resp_exp_t r_e;
    acc_exp_t  a_e;

    // Response monitor.
    always @(negedge clk) begin
        if (resp_valid) begin
            if (sb.size() == 0) begin
                check("resp_unexpected", {31'b0, resp_valid}, 32'd0);
            end else begin
                r_e = sb.pop_front();
                check({r_e.name, "_rdata"}, resp_rdata, r_e.rdata);
                check({r_e.name, "_err"}, {31'b0, resp_err}, {31'b0, r_e.err});
                check({r_e.name, "_latency"}, 32'(cyc - r_e.acc_cyc + 1), 32'(r_e.lat));
            end
        end
    end

    // Memory write-strobe monitor.
    always @(negedge clk) begin
        if (dmem_we) begin
            if (acc_q.size() == 0) begin
                check("we_unexpected", {31'b0, dmem_we}, 32'd0);
            end else begin
                a_e = acc_q.pop_front();
                check({a_e.name, "_addr"}, dmem_addr, a_e.addr);
                check({a_e.name, "_sel"}, {28'b0, dmem_wdata_sel}, {28'b0, a_e.sel});
                check({a_e.name, "_wdata"}, dmem_wdata, a_e.wdata);
            end
        end
    end

    task automatic issue(input string name, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input logic exp_err, input int exp_lat, input logic exp_acc,
                         input logic [3:0] exp_sel, input logic [31:0] exp_wdata);
        int waited = 0;
        resp_exp_t r;
        acc_exp_t  a;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            check({name, "_ready_timeout"}, {31'b0, req_ready}, 32'd1);
            req_valid = 1'b0;
            return;
        end
        r.name = name; r.rdata = exp_rdata; r.err = exp_err; r.lat = exp_lat; r.acc_cyc = cyc + 1;
        sb.push_back(r);
        if (exp_acc) begin
            a.name = name; a.addr = {addr[31:2], 2'b00}; a.sel = exp_sel; a.wdata = exp_wdata;
            acc_q.push_back(a);
        end
        @(posedge clk);
        #1;
        // Scramble the bus after acceptance; the latched request must win.
        req_valid = 1'b0;
        req_op    = 4'hF;
        req_addr  = ~addr;
        req_wdata = ~wdata;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || acc_q.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_outstanding", 32'(sb.size() + acc_q.size()), 32'd0);
    endtask

    logic [31:0] exp_ans;

    initial begin
        // Reset state.
        #3;
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", {31'b0, resp_err}, 32'd0);
        check("rst_dmem_we", {31'b0, dmem_we}, 32'd0);
        check("rst_dmem_addr", dmem_addr, 32'd0);
        check("rst_dmem_wdata", dmem_wdata, 32'd0);
        check("rst_ans_code", ans_code, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);

        // Stores: SW, and SW that seeds the load word.
        issue("sw_100", 4'hA, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b1, 4'hF, 32'hDEADBEEF);
        issue("sw_200", 4'hA, 32'h200, 32'h80FF7F01, 32'h0, 1'b0, 2, 1'b1, 4'hF, 32'h80FF7F01);

        // Loads from word 0x80FF7F01.
        issue("lb_202",  4'h0, 32'h202, 32'h0, 32'hFFFFFFFF, 1'b0, 3, 1'b0, 4'h0, 32'h0);
        issue("lbu_202", 4'h4, 32'h202, 32'h0, 32'h000000FF, 1'b0, 3, 1'b0, 4'h0, 32'h0);
        issue("lh_202",  4'h1, 32'h202, 32'h0, 32'hFFFF80FF, 1'b0, 3, 1'b0, 4'h0, 32'h0);
        issue("lhu_200", 4'h5, 32'h200, 32'h0, 32'h00007F01, 1'b0, 3, 1'b0, 4'h0, 32'h0);
        issue("lb_201",  4'h0, 32'h201, 32'h0, 32'h0000007F, 1'b0, 3, 1'b0, 4'h0, 32'h0);
        issue("lb_203",  4'h0, 32'h203, 32'h0, 32'hFFFFFF80, 1'b0, 3, 1'b0, 4'h0, 32'h0);
        issue("lw_200",  4'h2, 32'h200, 32'h0, 32'h80FF7F01, 1'b0, 3, 1'b0, 4'h0, 32'h0);

        // Sub-word stores, then read back the merged words.
        issue("sh_106", 4'h9, 32'h106, 32'h00001234, 32'h0, 1'b0, 2, 1'b1, 4'hC, 32'h12341234);
        issue("sb_101", 4'h8, 32'h101, 32'h000000AB, 32'h0, 1'b0, 2, 1'b1, 4'h2, 32'hABABABAB);
        issue("lw_100", 4'h2, 32'h100, 32'h0, 32'hDEADABEF, 1'b0, 3, 1'b0, 4'h0, 32'h0);
        issue("lw_104", 4'h2, 32'h104, 32'h0, 32'h12340000, 1'b0, 3, 1'b0, 4'h0, 32'h0);

        // Errors follow a nonzero load result, so the cleared rdata is visible.
        issue("lw_102_mis",  4'h2, 32'h102, 32'h0, 32'h0, 1'b1, 1, 1'b0, 4'h0, 32'h0);
        issue("op3_illegal", 4'h3, 32'h100, 32'h0, 32'h0, 1'b1, 1, 1'b0, 4'h0, 32'h0);
        issue("lhu_201_mis", 4'h5, 32'h201, 32'h0, 32'h0, 1'b1, 1, 1'b0, 4'h0, 32'h0);
        issue("sw_103_mis",  4'hA, 32'h103, 32'h5555AAAA, 32'h0, 1'b1, 1, 1'b0, 4'h0, 32'h0);
        issue("lw_200_again", 4'h2, 32'h200, 32'h0, 32'h80FF7F01, 1'b0, 3, 1'b0, 4'h0, 32'h0);
        drain();

        // Answer-code monitor.
        issue("sb_ans", 4'h8, 32'h10010003, 32'h0000005A, 32'h0, 1'b0, 2, 1'b1, 4'h8, 32'h5A5A5A5A);
        drain();
`ifdef LSU_ANSCODE_MON_EN
        exp_ans = 32'h5A000000;
`else
        exp_ans = 32'h00000000;
`endif
        check("ans_code", ans_code, exp_ans);

        // Reset during the ACCESS cycle of a store.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 4'hA;
        req_addr  = 32'h300;
        req_wdata = 32'h11111111;
        check("rstmid_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("rstmid_we_access", {31'b0, dmem_we}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rstmid_we_dropped", {31'b0, dmem_we}, 32'd0);
        check("rstmid_sel", {28'b0, dmem_wdata_sel}, 32'd0);
        check("rstmid_resp_rdata", resp_rdata, 32'd0);
        check("rstmid_ans_code", ans_code, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rstmid_ready_after", {31'b0, req_ready}, 32'd1);
        repeat (5) @(negedge clk);

        // Normal traffic afterwards.
        issue("sw_300", 4'hA, 32'h300, 32'hCAFEF00D, 32'h0, 1'b0, 2, 1'b1, 4'hF, 32'hCAFEF00D);
        issue("lw_300", 4'h2, 32'h300, 32'h0, 32'hCAFEF00D, 1'b0, 3, 1'b0, 4'h0, 32'h0);
        drain();
        repeat (3) @(negedge clk);
        check("hold_rdata", resp_rdata, 32'hCAFEF00D);
        check("hold_valid_low", {31'b0, resp_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
